pipo_rr_arbiter: RTL and testbench
==================================

# pipo_rr_arbiter

Round-robin arbiter and sequencer for a shared 4-bit parallel-in/parallel-out holding register. Up to N_REQ requesters compete for ownership. The owner loads the register every cycle while it holds its request. A hold-limit timeout stops any single requester from monopolising the register. The block contains the register itself, so downstream logic sees one registered parallel output plus ownership status.

## Interface
- N_REQ, 4, number of requesters (≥2)
- WIDTH, 4, data width of the shared register
- MAX_HOLD, 8, maximum loads per grant, grant-cycle load included (≥1)
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- req  input  N_REQ  per-requester level request
- data_in  input  N_REQ*WIDTH  requester i data on bits [i*WIDTH +: WIDTH]
- gnt  output  N_REQ  one-hot grant, registered; all-zero when no owner
- owner  output  $clog2(N_REQ)  index of current or last owner
- p_out  output  WIDTH  shared register contents
- out_valid  output  1  register has been loaded at least once since reset
- timeout  output  1  one-cycle pulse on forced release

## Operation
- Reset values: gnt=0, owner=0, p_out=0, out_valid=0, timeout=0, state IDLE, rr pointer=0, mask=0, hold count=0.
- States: IDLE and OWNED.
- IDLE, eligible requests present (eligible = req & ~mask):
  - Pick the first eligible index at or after the pointer, wrapping modulo N_REQ.
  - Next edge: gnt=onehot(winner), owner=winner, p_out=data_in[winner], out_valid=1, count=1, state OWNED.
- IDLE, no eligible requests: hold all outputs.
- OWNED, req[owner]=1 and count<MAX_HOLD: next edge p_out=data_in[owner], count+1.
- OWNED, req[owner]=0 (voluntary release): next edge gnt=0, pointer=owner+1 (wrap), state IDLE. p_out is not loaded.
- OWNED, req[owner]=1 and count==MAX_HOLD (forced release):
  - Next edge: gnt=0, timeout=1 for one cycle, mask[owner]=1, pointer=owner+1, state IDLE.
  - p_out is not loaded.
- Mask: mask[i] clears on any edge where req[i]=0. Masked requesters cannot win.
- Other requesters' req and data_in changes while OWNED are ignored.

## Timing
- Request-to-grant latency: 1 cycle from req sampled high in IDLE.
- Data latency: p_out updates at the same edge as the load decision. It reflects data_in[owner] sampled one cycle earlier.
- Grants are never back-to-back. At least one IDLE cycle with gnt=0 separates two grants.
- Simultaneous requests: the pointer decides the winner. After owner k releases, index k+1 has top priority.
- MAX_HOLD=1: grant cycle loads once. The next OWNED edge with req still high forces release.
- Reset mid-grant: all outputs return to reset values immediately (asynchronous). No partial load survives.
- owner and p_out keep their values after release until the next grant.

## Structure
- Package pipo_arb_pkg holds:
  - state enum (IDLE, OWNED)
  - default parameter constants
  - function for index width, $clog2(N_REQ) with minimum 1
- Sub-module rr_pick: combinational round-robin picker.
  - Inputs: eligible vector, pointer.
  - Outputs: one-hot winner, winner index, any-valid.
  - Instantiated once.
- Top holds the FSM, pointer, mask, hold counter and shared register.

## Test plan
- Reset: hold rst_n=0 with req=4'b1111 → gnt=0, p_out=0, out_valid=0, timeout=0.
- Single requester:
  - req=4'b0100, data_in[2]=4'b1100 → next edge gnt=4'b0100, owner=2, p_out=4'b1100, out_valid=1.
  - data_in[2]=4'b0110 next cycle → p_out=4'b0110.
  - Drop req[2] → gnt=0 at next edge, p_out stays 4'b0110.
- Round-robin:
  - req=4'b1111 held, each owner drops and re-raises req after 1 load → grants in order 0,1,2,3,0.
  - Each grant is separated by one gnt=0 cycle.
- Timeout, MAX_HOLD=3:
  - Requester 1 holds req with data 4'b1011 → three loads, then gnt=0 and timeout=1 for one cycle.
  - With req=4'b0010 still high, no re-grant occurs until req[1] drops for ≥1 cycle.
- Timeout with competitor:
  - As above with req[3]=1 → after forced release, requester 3 is granted after the IDLE cycle.
  - Requester 1 stays masked.
- Async reset mid-grant: assert rst_n=0 between clock edges while owner=2 → gnt, p_out, out_valid clear without waiting for a clock edge.

Source files
------------

// File: rtl/pipo_arb_pkg.sv
// Shared types and defaults for the round-robin holding-register arbiter.
// Sizing helpers keep index vectors at least one bit wide.
package pipo_arb_pkg;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    OWNED = 1'b1
  } arb_state_e;

  localparam int DEF_N_REQ    = 4;
  localparam int DEF_WIDTH    = 4;
  localparam int DEF_MAX_HOLD = 8;

  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first eligible index at or after the
// pointer, wrapping modulo N_REQ.
module rr_pick
  import pipo_arb_pkg::*;
#(
  parameter int N_REQ = DEF_N_REQ,
  parameter int IDX_W = idx_width(DEF_N_REQ)
) (
  input  logic [N_REQ-1:0] eligible_i,
  input  logic [IDX_W-1:0] ptr_i,
  output logic [N_REQ-1:0] onehot_o,
  output logic [IDX_W-1:0] idx_o,
  output logic             valid_o
);

  logic [IDX_W-1:0] cand;
  int               sum;

  // Scan from the pointer; the first hit locks out later candidates.
  always_comb begin
    onehot_o = '0;
    idx_o    = '0;
    valid_o  = 1'b0;
    cand     = '0;
    sum      = 0;
    for (int off = 0; off < N_REQ; off++) begin
      sum  = int'(ptr_i) + off;
      sum  = (sum >= N_REQ) ? (sum - N_REQ) : sum;
      cand = IDX_W'(sum);
      if (!valid_o && eligible_i[cand]) begin
        valid_o        = 1'b1;
        idx_o          = cand;
        onehot_o[cand] = 1'b1;
      end else begin
        valid_o = valid_o;
      end
    end
  end

endmodule

// File: rtl/pipo_rr_arbiter.sv
// Round-robin arbiter owning a shared parallel-in/parallel-out register,
// with a per-grant load limit that forces release and masks the hog.
module pipo_rr_arbiter
  import pipo_arb_pkg::*;
#(
  parameter int  N_REQ    = DEF_N_REQ,
  parameter int  WIDTH    = DEF_WIDTH,
  parameter int  MAX_HOLD = DEF_MAX_HOLD,
  localparam int IDX_W    = idx_width(N_REQ)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [N_REQ-1:0]       req_i,
  input  logic [N_REQ*WIDTH-1:0] data_in_i,
  output logic [N_REQ-1:0]       gnt_o,
  output logic [IDX_W-1:0]       owner_o,
  output logic [WIDTH-1:0]       p_out_o,
  output logic                   out_valid_o,
  output logic                   timeout_o
);

  localparam int CNT_W = $clog2(MAX_HOLD + 1);

  arb_state_e       state_q, state_d;
  logic [IDX_W-1:0] ptr_q, ptr_d;
  logic [N_REQ-1:0] mask_q, mask_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [N_REQ-1:0] gnt_q, gnt_d;
  logic [IDX_W-1:0] owner_q, owner_d;
  logic [WIDTH-1:0] p_out_q, p_out_d;
  logic             out_valid_q, out_valid_d;
  logic             timeout_q, timeout_d;

  logic [WIDTH-1:0] data_arr_s [N_REQ];
  logic [N_REQ-1:0] eligible_s;
  logic [N_REQ-1:0] pick_onehot_s;
  logic [IDX_W-1:0] pick_idx_s;
  logic             pick_valid_s;
  logic [IDX_W-1:0] next_ptr_s;

  for (genvar i = 0; i < N_REQ; i++) begin : g_unpack
    assign data_arr_s[i] = data_in_i[i*WIDTH +: WIDTH];
  end

  assign eligible_s = req_i & ~mask_q;
  assign next_ptr_s = (owner_q == IDX_W'(N_REQ - 1)) ? '0 : (owner_q + IDX_W'(1));

  rr_pick #(
    .N_REQ (N_REQ),
    .IDX_W (IDX_W)
  ) u_pick (
    .eligible_i (eligible_s),
    .ptr_i      (ptr_q),
    .onehot_o   (pick_onehot_s),
    .idx_o      (pick_idx_s),
    .valid_o    (pick_valid_s)
  );

  // Next-state: grant selection, hold-limit release and mask maintenance.
  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    mask_d      = mask_q & req_i;
    cnt_d       = cnt_q;
    gnt_d       = gnt_q;
    owner_d     = owner_q;
    p_out_d     = p_out_q;
    out_valid_d = out_valid_q;
    timeout_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (pick_valid_s) begin
          state_d     = OWNED;
          gnt_d       = pick_onehot_s;
          owner_d     = pick_idx_s;
          p_out_d     = data_arr_s[pick_idx_s];
          out_valid_d = 1'b1;
          cnt_d       = CNT_W'(1);
        end else begin
          state_d = IDLE;
        end
      end
      OWNED: begin
        if (!req_i[owner_q]) begin
          state_d = IDLE;
          gnt_d   = '0;
          ptr_d   = next_ptr_s;
        end else if (cnt_q >= CNT_W'(MAX_HOLD)) begin
          // Mask bit is set even though req is high, so it overrides the clear.
          state_d         = IDLE;
          gnt_d           = '0;
          ptr_d           = next_ptr_s;
          timeout_d       = 1'b1;
          mask_d[owner_q] = 1'b1;
        end else begin
          p_out_d = data_arr_s[owner_q];
          cnt_d   = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
        gnt_d   = '0;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      ptr_q       <= '0;
      mask_q      <= '0;
      cnt_q       <= '0;
      gnt_q       <= '0;
      owner_q     <= '0;
      p_out_q     <= '0;
      out_valid_q <= 1'b0;
      timeout_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      mask_q      <= mask_d;
      cnt_q       <= cnt_d;
      gnt_q       <= gnt_d;
      owner_q     <= owner_d;
      p_out_q     <= p_out_d;
      out_valid_q <= out_valid_d;
      timeout_q   <= timeout_d;
    end
  end

  assign gnt_o       = gnt_q;
  assign owner_o     = owner_q;
  assign p_out_o     = p_out_q;
  assign out_valid_o = out_valid_q;
  assign timeout_o   = timeout_q;

endmodule

// File: tb/tb_pipo_rr_arbiter.sv
// Directed plus randomized bench for pipo_rr_arbiter (4 requesters, hold
// limit 3) against a behavioural ownership model.
module tb_pipo_rr_arbiter;

  localparam int N    = 4;
  localparam int W    = 4;
  localparam int MAXH = 3;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [3:0]   req;
  logic [3:0]   d [4];
  logic [15:0]  data_in;
  logic [3:0]   gnt;
  logic [1:0]   owner;
  logic [3:0]   p_out;
  logic         out_valid;
  logic         timeout;

  int checks = 0;
  int failures = 0;

  // Behavioural model state
  bit         m_busy, m_valid, m_timeout;
  logic [1:0] m_owner, m_ptr;
  logic [3:0] m_mask, m_pout;
  int         m_loads;

  assign data_in = {d[3], d[2], d[1], d[0]};

  always #5 clk = ~clk;

  pipo_rr_arbiter #(
    .N_REQ    (N),
    .WIDTH    (W),
    .MAX_HOLD (MAXH)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req_i       (req),
    .data_in_i   (data_in),
    .gnt_o       (gnt),
    .owner_o     (owner),
    .p_out_o     (p_out),
    .out_valid_o (out_valid),
    .timeout_o   (timeout)
  );

  task automatic model_reset();
    m_busy = 0; m_valid = 0; m_timeout = 0;
    m_owner = 2'd0; m_ptr = 2'd0; m_mask = 4'd0; m_pout = 4'd0; m_loads = 0;
  endtask

  // Advance the model by one clock edge using the inputs currently driven.
  task automatic model_step();
    logic [3:0] nmask;
    logic [1:0] c;
    logic [1:0] win;
    bit         found;
    nmask = m_mask & req;
    m_timeout = 0;
    found = 0;
    win = 2'd0;
    if (!m_busy) begin
      for (int k = 0; k < N; k++) begin
        c = m_ptr + 2'(k);
        if (!found && req[c] && !m_mask[c]) begin
          found = 1;
          win = c;
        end
      end
      if (found) begin
        m_busy = 1; m_owner = win; m_pout = d[win]; m_valid = 1; m_loads = 1;
      end
    end else if (!req[m_owner]) begin
      m_busy = 0;
      m_ptr = m_owner + 2'd1;
    end else if (m_loads >= MAXH) begin
      m_busy = 0;
      m_timeout = 1;
      nmask[m_owner] = 1'b1;
      m_ptr = m_owner + 2'd1;
    end else begin
      m_pout = d[m_owner];
      m_loads++;
    end
    m_mask = nmask;
  endtask

  task automatic chk(input string tag);
    logic [3:0] eg;
    eg = m_busy ? (4'b0001 << m_owner) : 4'b0000;
    checks++;
    assert (gnt === eg) else begin
      failures++; $error("FAIL %s gnt got=%b exp=%b", tag, gnt, eg);
    end
    checks++;
    assert (owner === m_owner) else begin
      failures++; $error("FAIL %s owner got=%0d exp=%0d", tag, owner, m_owner);
    end
    checks++;
    assert (p_out === m_pout) else begin
      failures++; $error("FAIL %s p_out got=%b exp=%b", tag, p_out, m_pout);
    end
    checks++;
    assert (out_valid === m_valid) else begin
      failures++; $error("FAIL %s out_valid got=%b exp=%b", tag, out_valid, m_valid);
    end
    checks++;
    assert (timeout === m_timeout) else begin
      failures++; $error("FAIL %s timeout got=%b exp=%b", tag, timeout, m_timeout);
    end
  endtask

  task automatic expect4(input string tag, input logic [3:0] got, input logic [3:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++; $error("FAIL %s got=%b exp=%b", tag, got, exp);
    end
  endtask

  task automatic cycle(input string tag);
    model_step();
    @(posedge clk);
    #1;
    chk(tag);
  endtask

  initial begin
    logic [1:0] rr_exp [5];
    rr_exp[0] = 2'd0; rr_exp[1] = 2'd1; rr_exp[2] = 2'd2; rr_exp[3] = 2'd3; rr_exp[4] = 2'd0;
    for (int i = 0; i < N; i++) d[i] = 4'($urandom);

    // Reset held with all requests active
    rst_n = 1'b0;
    req = 4'b1111;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("reset");
    expect4("reset_gnt", gnt, 4'b0000);
    req = 4'b0000;
    rst_n = 1'b1;
    cycle("idle");

    // Single requester
    req = 4'b0100; d[2] = 4'b1100;
    cycle("single_grant");
    expect4("single_gnt", gnt, 4'b0100);
    expect4("single_owner", {2'b00, owner}, 4'd2);
    expect4("single_pout", p_out, 4'b1100);
    expect4("single_valid", {3'b000, out_valid}, 4'b0001);
    d[2] = 4'b0110;
    cycle("single_load2");
    expect4("single_pout2", p_out, 4'b0110);
    req = 4'b0000; d[2] = 4'b1111;
    cycle("single_release");
    expect4("release_gnt", gnt, 4'b0000);
    expect4("release_pout", p_out, 4'b0110);

    // Round-robin from a freshly reset pointer
    @(posedge clk); #1;
    rst_n = 1'b0; #1; rst_n = 1'b1;
    model_reset();
    req = 4'b1111;
    for (int g = 0; g < 5; g++) begin
      for (int i = 0; i < N; i++) d[i] = 4'($urandom);
      cycle("rr_grant");
      expect4("rr_owner", {2'b00, owner}, {2'b00, rr_exp[g]});
      req[rr_exp[g]] = 1'b0;
      cycle("rr_gap");
      expect4("rr_gap_gnt", gnt, 4'b0000);
      req[rr_exp[g]] = 1'b1;
    end
    req = 4'b0000;
    cycle("rr_end");

    // Forced release after MAX_HOLD loads, hog stays masked
    req = 4'b0010; d[1] = 4'b1011;
    for (int i = 0; i < MAXH; i++) begin
      cycle("to_load");
      expect4("to_load_gnt", gnt, 4'b0010);
    end
    cycle("to_force");
    expect4("to_force_gnt", gnt, 4'b0000);
    expect4("to_pulse", {3'b000, timeout}, 4'b0001);
    expect4("to_pout", p_out, 4'b1011);
    repeat (3) begin
      cycle("to_masked");
      expect4("to_masked_gnt", gnt, 4'b0000);
    end
    req = 4'b0000;
    cycle("to_drop");
    req = 4'b0010;
    cycle("to_regrant");
    expect4("to_regrant_gnt", gnt, 4'b0010);
    req = 4'b0000;
    cycle("to_regrant_rel");

    // Forced release with a competitor waiting
    req = 4'b0010;
    cycle("comp_grant1");
    req = 4'b1010;
    repeat (MAXH - 1) cycle("comp_load");
    cycle("comp_force");
    expect4("comp_force_to", {3'b000, timeout}, 4'b0001);
    cycle("comp_grant3");
    expect4("comp_gnt3", gnt, 4'b1000);
    req = 4'b0010;
    cycle("comp_rel3");
    cycle("comp_masked");
    expect4("comp_masked_gnt", gnt, 4'b0000);

    // Randomized traffic
    for (int n = 0; n < 400; n++) begin
      if ($urandom_range(0, 2) == 0) req = 4'($urandom);
      for (int i = 0; i < N; i++) d[i] = 4'($urandom);
      cycle("rand");
    end

    // Asynchronous reset while requester 2 owns the register
    req = 4'b0000;
    cycle("ar_clear1");
    cycle("ar_clear2");
    req = 4'b0100; d[2] = 4'b1001;
    cycle("ar_grant");
    expect4("ar_owner", {2'b00, owner}, 4'd2);
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    expect4("ar_gnt", gnt, 4'b0000);
    expect4("ar_pout", p_out, 4'b0000);
    expect4("ar_valid", {3'b000, out_valid}, 4'b0000);
    chk("ar_async");
    @(posedge clk); #1;
    req = 4'b0000;
    rst_n = 1'b1;
    cycle("ar_after");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
